// File: rtl/serial_deserializer.sv
// ============================================================================
// serial_deserializer: LSB-first serial-to-parallel word assembler with a
// one-word output register and ready/valid handshake toward the FIR.
// Revision: 1.0
// ============================================================================
`default_nettype none

module serial_deserializer #(
  parameter int DATA_WIDTH = 24
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_din,
  input  logic                  i_din_valid,
  output logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_dout,
  output logic                  o_dout_valid,
  input  logic                  i_ready
);

  localparam int              CW       = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0]   LAST_CNT = CW'(DATA_WIDTH - 1);
  localparam logic [1:0]      S_IDLE   = 2'd0;
  localparam logic [1:0]      S_SHIFT  = 2'd1;
  localparam logic [1:0]      S_FULL   = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  dout_valid_q, dout_valid_d;

  logic                  w_xfer;
  logic                  w_last;
  logic                  w_hs;
  logic                  w_out_free;
  logic [DATA_WIDTH-1:0] w_shifted;

  assign w_xfer     = o_ready & i_din_valid;
  assign w_last     = w_xfer & (count_q == LAST_CNT);
  assign w_hs       = dout_valid_q & i_ready;
  // The output register can take a new word if empty or drained this edge.
  assign w_out_free = ~dout_valid_q | w_hs;
  assign w_shifted  = {i_din, shift_q[DATA_WIDTH-1:1]};

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      shift_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      shift_q      <= shift_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (w_xfer) state_d = S_SHIFT;
      S_SHIFT: if (w_last) state_d = w_out_free ? S_IDLE : S_FULL;
      S_FULL:  if (w_hs)   state_d = S_IDLE;
      default:             state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_ready      = i_rst & i_en & (state_q != S_FULL);
    count_d      = count_q;
    shift_d      = shift_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    if (w_xfer) begin
      count_d = w_last ? '0 : count_q + CW'(1);
      shift_d = w_shifted;
    end
    // A parked word refills the output register on the draining edge.
    if ((state_q == S_FULL) && w_hs) begin
      dout_d       = shift_q;
      dout_valid_d = 1'b1;
    end else if (w_last && w_out_free) begin
      dout_d       = w_shifted;
      dout_valid_d = 1'b1;
    end else if (w_hs) begin
      dout_valid_d = 1'b0;
    end
  end

  assign o_dout       = dout_q;
  assign o_dout_valid = dout_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_deserializer.sv
// ============================================================================
// tb_serial_deserializer: directed bench with a word scoreboard checked at
// each output handshake.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_serial_deserializer;

  localparam int W = 24;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_en;
  logic         i_din;
  logic         i_din_valid;
  logic         o_ready;
  logic [W-1:0] o_dout;
  logic         o_dout_valid;
  logic         i_ready;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] sb_q[$];

  serial_deserializer #(.DATA_WIDTH(W)) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_en(i_en),
    .i_din(i_din),
    .i_din_valid(i_din_valid),
    .o_ready(o_ready),
    .o_dout(o_dout),
    .o_dout_valid(o_dout_valid),
    .i_ready(i_ready)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_bits(input logic [W-1:0] w, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      i_en        = 1'b1;
      i_din       = w[i];
      i_din_valid = 1'b1;
      tick();
    end
    i_din_valid = 1'b0;
  endtask

  // Handshake occurs on the posedge following a negedge with valid & ready.
  always @(negedge i_clk) begin
    if (i_rst && o_dout_valid && i_ready) begin
      if (sb_q.size() == 0) chk("sb_unexpected_word", 32'(o_dout), 32'hDEAD);
      else                  chk("sb_word", 32'(o_dout), 32'(sb_q.pop_front()));
    end
  end

  initial begin
    i_rst = 1'b0; i_en = 1'b1; i_din = 1'b0; i_din_valid = 1'b0; i_ready = 1'b1;
    #3;
    chk("rst_dout", 32'(o_dout), 32'h0);
    chk("rst_valid", 32'(o_dout_valid), 32'h0);
    chk("rst_ready", 32'(o_ready), 32'h0);
    tick();
    i_rst = 1'b1;
    #1;
    chk("post_rst_ready", 32'(o_ready), 32'h1);

    // Single word, continuous valid
    sb_q.push_back(24'hABCDEF);
    send_bits(24'hABCDEF, 0, 22);
    chk("w1_not_yet_valid", 32'(o_dout_valid), 32'h0);
    send_bits(24'hABCDEF, 23, 23);
    chk("w1_valid", 32'(o_dout_valid), 32'h1);
    chk("w1_dout", 32'(o_dout), 32'hABCDEF);
    tick();
    chk("w1_valid_one_cycle", 32'(o_dout_valid), 32'h0);

    // Gap in valid mid-word
    sb_q.push_back(24'hFFF000);
    send_bits(24'hFFF000, 0, 7);
    for (int i = 0; i < 5; i++) tick();
    chk("gap_count_hold", 32'(dut.count_q), 32'd8);
    chk("gap_no_valid", 32'(o_dout_valid), 32'h0);
    send_bits(24'hFFF000, 8, 23);
    chk("gap_dout", 32'(o_dout), 32'hFFF000);
    tick();

    // Backpressure
    i_ready = 1'b0;
    sb_q.push_back(24'h000001);
    sb_q.push_back(24'h800000);
    send_bits(24'h000001, 0, 23);
    chk("bp_w1_dout", 32'(o_dout), 32'h000001);
    send_bits(24'h800000, 0, 23);
    chk("bp_ready_low", 32'(o_ready), 32'h0);
    for (int i = 0; i < 3; i++) tick();
    chk("bp_hold_dout", 32'(o_dout), 32'h000001);
    chk("bp_hold_valid", 32'(o_dout_valid), 32'h1);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    chk("bp_w2_dout", 32'(o_dout), 32'h800000);
    chk("bp_w2_valid", 32'(o_dout_valid), 32'h1);
    chk("bp_ready_back", 32'(o_ready), 32'h1);
    i_ready = 1'b1;
    tick();
    chk("bp_drained", 32'(o_dout_valid), 32'h0);

    // Last bit lands on the consume edge of the previous word
    i_ready = 1'b0;
    sb_q.push_back(24'h123456);
    send_bits(24'h123456, 0, 23);
    sb_q.push_back(24'h5A5A5A);
    send_bits(24'h5A5A5A, 0, 22);
    i_ready = 1'b1;
    send_bits(24'h5A5A5A, 23, 23);
    chk("sim_dout", 32'(o_dout), 32'h5A5A5A);
    chk("sim_valid_held", 32'(o_dout_valid), 32'h1);
    tick();
    chk("sim_drained", 32'(o_dout_valid), 32'h0);

    // Reset mid-word
    send_bits(24'hFFFFFF, 0, 9);
    i_rst = 1'b0;
    #2;
    chk("mid_rst_dout", 32'(o_dout), 32'h0);
    chk("mid_rst_valid", 32'(o_dout_valid), 32'h0);
    chk("mid_rst_ready", 32'(o_ready), 32'h0);
    chk("mid_rst_count", 32'(dut.count_q), 32'h0);
    tick();
    i_rst = 1'b1;
    sb_q.push_back(24'h00000F);
    send_bits(24'h00000F, 0, 23);
    chk("after_rst_dout", 32'(o_dout), 32'h00000F);
    tick();

    // Enable gating
    sb_q.push_back(24'h3C96A5);
    send_bits(24'h3C96A5, 0, 4);
    i_en = 1'b0;
    i_din = 1'b1;
    i_din_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (i == 0 || i == 29) begin
        chk("en_ready_low", 32'(o_ready), 32'h0);
        chk("en_count_hold", 32'(dut.count_q), 32'd5);
        chk("en_no_valid", 32'(o_dout_valid), 32'h0);
      end
    end
    i_din_valid = 1'b0;
    send_bits(24'h3C96A5, 5, 23);
    chk("en_dout", 32'(o_dout), 32'h3C96A5);
    tick();
    tick();

    chk("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_deserializer.md
SERIAL_DESERIALIZER -- requirements
Module: serial_deserializer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 24, giving the parallel word width in bits (allowed range 2..32).
REQ-002 The block SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port i_rst, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-004 The block SHALL have port i_en, input, 1 bit: stage enable.
REQ-005 The block SHALL have port i_din, input, 1 bit: serial data, LSB first.
REQ-006 The block SHALL have port i_din_valid, input, 1 bit: i_din carries a valid bit this cycle.
REQ-007 The block SHALL have port o_ready, output, 1 bit: the block will accept a serial bit this cycle.
REQ-008 The block SHALL have port o_dout, output, DATA_WIDTH bits: assembled parallel word to the FIR.
REQ-009 The block SHALL have port o_dout_valid, output, 1 bit: o_dout holds an unconsumed word.
REQ-010 The block SHALL have port i_ready, input, 1 bit: the FIR accepts o_dout this cycle.

Function
REQ-011 A serial bit SHALL be accepted on a rising edge exactly when i_en=1, i_din_valid=1 and o_ready=1 (bit transfer).
REQ-012 Accepted bits SHALL be shifted in from the MSB side (shift_reg <= {i_din, shift_reg[DATA_WIDTH-1:1]}), so the first accepted bit becomes word bit 0.
REQ-013 A bit counter SHALL count transfers 0..DATA_WIDTH-1, wrap to 0 on the DATA_WIDTH-th transfer, and hold while no transfer occurs.
REQ-014 The FSM SHALL have states IDLE (count=0, no word pending), SHIFT (0<count<DATA_WIDTH), FULL (complete word in shift_reg, output register occupied).
REQ-015 IDLE->SHIFT on the first transfer; SHIFT->IDLE on the DATA_WIDTH-th transfer when the output register is free or is consumed on that same edge; SHIFT->FULL on the DATA_WIDTH-th transfer otherwise; FULL->IDLE on the output-handshake edge.
REQ-016 An output handshake SHALL occur on a rising edge when o_dout_valid=1 and i_ready=1; it occurs regardless of i_en.
REQ-017 On the DATA_WIDTH-th transfer edge, with the output free or consumed that edge, o_dout SHALL load the complete word and o_dout_valid SHALL be 1 from the following cycle (latency 1 clock after the last bit edge).
REQ-018 In FULL, on the handshake edge, o_dout SHALL load the word from shift_reg and o_dout_valid SHALL remain 1.
REQ-019 Without a handshake or new word, o_dout_valid SHALL fall to 0 on the handshake edge, and o_dout SHALL hold its last value.
REQ-020 o_dout and o_dout_valid SHALL stay stable while o_dout_valid=1 and i_ready=0.
REQ-021 o_ready SHALL be combinational: 1 when i_en=1 and state is not FULL, else 0; it SHALL NOT depend on i_din_valid.
REQ-022 When i_din_valid=0 mid-word, count and shift_reg SHALL hold indefinitely; there SHALL be no timeout.
REQ-023 When i_en=0, shifting SHALL stop and state SHALL hold, with output handshake still honoured.
REQ-024 o_dout SHALL be raw bit order with no sign or width manipulation; a two's-complement word passes unchanged.

Reset
REQ-025 While i_rst=0, asynchronously: state=IDLE, count=0, shift_reg=0, o_dout=0, o_dout_valid=0.
REQ-026 o_ready SHALL be 0 while i_rst=0; after i_rst rises it follows REQ-021.
REQ-027 Reset mid-word SHALL discard the partial word; the first transfer after release becomes bit 0 of a new word.

Verification
REQ-028 Single word, i_ready=1: serialize 24'hABCDEF LSB first, i_din_valid continuous -> o_dout=24'hABCDEF; o_dout_valid high exactly one cycle, starting one cycle after the 24th bit edge.
REQ-029 Negative sample: send 24'hFFF000 with i_din_valid dropped for 5 cycles after bit 7 -> o_dout=24'hFFF000; count holds at 8 during the gap.
REQ-030 Backpressure, i_ready=0: send 24'h000001 then 24'h800000 -> first word held stable; o_ready falls after the 48th bit edge; raising i_ready for one cycle shows o_dout=24'h800000 with o_dout_valid continuously high; o_ready returns to 1.
REQ-031 Simultaneous events: with i_ready=1, send the last bit of 24'h5A5A5A on the same edge the previous word 24'h123456 is consumed -> o_dout=24'h5A5A5A next cycle, o_dout_valid never drops.
REQ-032 Reset mid-word: assert i_rst=0 after 10 bits of 24'hFFFFFF, release, send 24'h00000F -> all outputs 0 during reset; received word 24'h00000F.
REQ-033 Enable gating: i_en=0 with i_din_valid=1 for 30 cycles -> o_ready=0, count unchanged, no o_dout_valid.
